// File: rtl/awg_stream_sequencer.sv
// Frame-level AWG playback controller: header parser, sample FIFO, rate-timed DAC output.
// Define AWG_SEQ_TRIG_SYNC_EN to add a 2-flop synchronizer on trig_in (asynchronous trigger sources).
module awg_stream_sequencer #(
  parameter int unsigned FIFO_AW = 14,
  parameter int unsigned PREFILL = 1024
) (
  input  logic       clk100,
  input  logic       rst,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic [7:0] s_tdata,
  input  logic       trig_in,
  input  logic       err_clr,
  output logic [7:0] dac,
  output logic       dac_valid,
  output logic       busy,
  output logic [2:0] state,
  output logic       underrun,
  output logic       error
);

  localparam int unsigned PW    = FIFO_AW + 1;
  localparam int unsigned DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {
    S_HDR_MODE = 3'd0,
    S_HDR_LEN  = 3'd1,
    S_HDR_RATE = 3'd2,
    S_FILL     = 3'd3,
    S_ARM      = 3'd4,
    S_PLAY     = 3'd5,
    S_ERROR    = 3'd6
  } state_t;

  state_t        st;
  logic          run_q;
  logic          mode_q;
  logic [1:0]    byte_cnt;
  logic [31:0]   n_q;
  logic [31:0]   rx_rem;
  logic [31:0]   play_rem;
  logic [15:0]   r_q;
  logic [15:0]   rate_cnt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] level;
  logic          empty;
  logic          full;
  logic          payload_st;
  logic          accept;
  logic          push;
  logic          tick;
  logic          pop;
  logic          trig_rise;
  logic [31:0]   n_next;
  logic [7:0]    mem [DEPTH];

  assign level      = wr_ptr - rd_ptr;
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]) &&
                      (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]);
  assign payload_st = (st == S_FILL) || (st == S_ARM) || (st == S_PLAY);
  assign accept     = s_tvalid && s_tready;
  assign push       = accept && payload_st;
  assign tick       = (st == S_PLAY) && (rate_cnt == 16'd0);
  assign pop        = tick && !empty;
  assign n_next     = {s_tdata, n_q[31:8]};
  assign busy       = (st != S_HDR_MODE);
  assign state      = st;

  // Ready is held low in the reset cycle via run_q
  always_comb begin
    s_tready = 1'b0;
    if (run_q) begin
      if (st == S_HDR_MODE || st == S_HDR_LEN || st == S_HDR_RATE)
        s_tready = 1'b1;
      else if (payload_st)
        s_tready = (rx_rem != 32'd0) && !full;
    end
  end

`ifdef AWG_SEQ_TRIG_SYNC_EN
  logic [2:0] trig_sh;
  logic       rise_q;
  always_ff @(posedge clk100) begin
    if (rst) begin
      trig_sh <= 3'd0;
      rise_q  <= 1'b0;
    end else begin
      trig_sh <= {trig_sh[1:0], trig_in};
      rise_q  <= trig_sh[1] && !trig_sh[2];
    end
  end
  assign trig_rise = rise_q;
`else
  logic trig_q;
  always_ff @(posedge clk100) begin
    if (rst) trig_q <= 1'b0;
    else     trig_q <= trig_in;
  end
  assign trig_rise = trig_in && !trig_q;
`endif

  // Sample storage, no reset so it can map onto block RAM
  always_ff @(posedge clk100) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= s_tdata;
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      st        <= S_HDR_MODE;
      run_q     <= 1'b0;
      mode_q    <= 1'b0;
      byte_cnt  <= 2'd0;
      n_q       <= 32'd0;
      r_q       <= 16'd0;
      rx_rem    <= 32'd0;
      play_rem  <= 32'd0;
      rate_cnt  <= 16'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      dac       <= 8'd0;
      dac_valid <= 1'b0;
      underrun  <= 1'b0;
      error     <= 1'b0;
    end else begin
      run_q     <= 1'b1;
      dac_valid <= 1'b0;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        rx_rem <= rx_rem - 32'd1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PW'(1);
        play_rem  <= play_rem - 32'd1;
        dac       <= mem[rd_ptr[FIFO_AW-1:0]];
        dac_valid <= 1'b1;
      end
      if (err_clr && st != S_ERROR) underrun <= 1'b0;
      if (tick && empty) underrun <= 1'b1;

      case (st)
        S_HDR_MODE: begin
          if (accept) begin
            if (s_tdata > 8'd1) begin
              error <= 1'b1;
              st    <= S_ERROR;
            end else begin
              mode_q   <= s_tdata[0];
              byte_cnt <= 2'd0;
              st       <= S_HDR_LEN;
            end
          end
        end
        S_HDR_LEN: begin
          if (accept) begin
            n_q      <= n_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              byte_cnt <= 2'd0;
              if (n_next == 32'd0) begin
                error <= 1'b1;
                st    <= S_ERROR;
              end else begin
                st <= S_HDR_RATE;
              end
            end
          end
        end
        S_HDR_RATE: begin
          if (accept) begin
            r_q      <= {s_tdata, r_q[15:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd1) begin
              byte_cnt <= 2'd0;
              rx_rem   <= n_q;
              play_rem <= n_q;
              st       <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (level >= PW'(PREFILL) || rx_rem == 32'd0) begin
            if (mode_q) begin
              st <= S_ARM;
            end else begin
              rate_cnt <= 16'd0;
              st       <= S_PLAY;
            end
          end
        end
        S_ARM: begin
          if (trig_rise) begin
            rate_cnt <= 16'd0;
            st       <= S_PLAY;
          end
        end
        S_PLAY: begin
          rate_cnt <= (rate_cnt == r_q) ? 16'd0 : rate_cnt + 16'd1;
          if (pop && play_rem == 32'd1) st <= S_HDR_MODE;
        end
        S_ERROR: begin
          if (err_clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            underrun <= 1'b0;
            error    <= 1'b0;
            st       <= S_HDR_MODE;
          end
        end
        default: st <= S_HDR_MODE;
      endcase
    end
  end

endmodule
